// File: rtl/prbs9_upsampler_if.sv
// prbs9_upsampler_if: strobe/phase inputs and sample-stream outputs of prbs9_upsampler
interface prbs9_upsampler_if #(
    parameter int NB_SAMPLE = 8
);
    logic                 i_enable;
    logic                 i_valid;
    logic [2:0]           i_phase;
    logic                 o_bit;
    logic [NB_SAMPLE-1:0] o_sample;
    logic                 o_sample_valid;
    logic                 o_period;
    logic                 o_phase_err;
    logic [8:0]           o_lfsr;
    modport master (
        output i_enable, i_valid, i_phase,
        input  o_bit, o_sample, o_sample_valid, o_period, o_phase_err, o_lfsr
    );
    modport slave (
        input  i_enable, i_valid, i_phase,
        output o_bit, o_sample, o_sample_valid, o_period, o_phase_err, o_lfsr
    );
endinterface

// File: rtl/prbs9_upsampler.sv
// prbs9_upsampler: PRBS9 (x^9+x^5+1) symbol source emitting a 4x zero-stuffed +/-AMPLITUDE impulse stream
module prbs9_upsampler #(
    parameter logic [8:0] SEED      = 9'h1AA,
    parameter int         NB_SAMPLE = 8,
    parameter int         AMPLITUDE = 64
) (
    input logic           clock,
    input logic           i_reset,
    prbs9_upsampler_if.slave bus
);
    // an all-zero seed would lock the LFSR, so it is replaced by all-ones
    localparam logic [8:0]           SEED_OK = (SEED == 9'h000) ? 9'h1FF : SEED;
    localparam logic [NB_SAMPLE-1:0] POS     = NB_SAMPLE'(AMPLITUDE);
    localparam logic [NB_SAMPLE-1:0] NEG     = NB_SAMPLE'(-AMPLITUDE);
    logic [8:0]           lfsr_q, lfsr_d;
    logic [8:0]           cnt_q, cnt_d;
    logic                 bit_q, bit_d;
    logic [NB_SAMPLE-1:0] sample_q, sample_d;
    logic                 svalid_q, svalid_d;
    logic                 period_q, period_d;
    logic                 perr_q, perr_d;
    logic                 adv;
    assign adv = bus.i_enable & bus.i_valid;
    always_comb begin
        lfsr_d   = adv ? {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]} : lfsr_q;
        cnt_d    = adv ? ((cnt_q == 9'd510) ? 9'd0 : cnt_q + 9'd1) : cnt_q;
        bit_d    = adv ? lfsr_q[8] : bit_q;
        sample_d = !bus.i_enable ? sample_q : adv ? (lfsr_q[8] ? POS : NEG) : '0;
        svalid_d = bus.i_enable;
        period_d = adv & (cnt_q == 9'd510);
        perr_d   = perr_q | (adv & (bus.i_phase != 3'd0));
    end
    always_ff @(posedge clock) begin
        if (i_reset) begin
            lfsr_q   <= SEED_OK;
            cnt_q    <= '0;
            bit_q    <= 1'b0;
            sample_q <= '0;
            svalid_q <= 1'b0;
            period_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sample_q <= sample_d;
            svalid_q <= svalid_d;
            period_q <= period_d;
            perr_q   <= perr_d;
        end
    end
    assign bus.o_bit          = bit_q;
    assign bus.o_sample       = sample_q;
    assign bus.o_sample_valid = svalid_q;
    assign bus.o_period       = period_q;
    assign bus.o_phase_err    = perr_q;
    assign bus.o_lfsr         = lfsr_q;
endmodule

// File: tb/tb_prbs9_upsampler.sv
// tb_prbs9_upsampler: checks two upsampler instances (normal seed, zero seed) against a bit-sequence model
module tb_prbs9_upsampler;
    logic clock = 1'b0;
    logic i_reset;
    int total = 0;
    int bad = 0;
    prbs9_upsampler_if #(.NB_SAMPLE(8)) bus0 ();
    prbs9_upsampler_if #(.NB_SAMPLE(6)) bus1 ();
    prbs9_upsampler #(.SEED(9'h1AA), .NB_SAMPLE(8), .AMPLITUDE(64)) dut0 (
        .clock(clock), .i_reset(i_reset), .bus(bus0)
    );
    prbs9_upsampler #(.SEED(9'h000), .NB_SAMPLE(6), .AMPLITUDE(31)) dut1 (
        .clock(clock), .i_reset(i_reset), .bus(bus1)
    );
    always #5 clock = ~clock;

    // model: the PRBS output is a bit sequence s with s[i] = s[i-9] ^ s[i-5], seeded MSB-first
    bit         s [2][2100];
    int         n [2];
    int         amp [2] = '{64, 31};
    logic [8:0] seeds [2] = '{9'h1AA, 9'h1FF};
    logic       e_bit [2], e_sv [2], e_per [2], e_perr [2];
    int         e_samp [2];

    function automatic logic [8:0] exp_lfsr(int k);
        logic [8:0] r;
        for (int j = 0; j < 9; j++) r[8-j] = s[k][n[k]+j];
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(logic r, logic en, logic v, logic [2:0] ph);
        logic [7:0] e8;
        logic [5:0] e6;
        i_reset = r;
        bus0.i_enable = en; bus0.i_valid = v; bus0.i_phase = ph;
        bus1.i_enable = en; bus1.i_valid = v; bus1.i_phase = ph;
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                n[k] = 0; e_bit[k] = 0; e_samp[k] = 0; e_sv[k] = 0; e_per[k] = 0; e_perr[k] = 0;
            end else begin
                e_sv[k] = en;
                e_per[k] = 0;
                if (en && v) begin
                    e_bit[k] = s[k][n[k]];
                    e_samp[k] = e_bit[k] ? amp[k] : -amp[k];
                    n[k]++;
                    e_per[k] = (n[k] % 511 == 0);
                    if (ph != 3'd0) e_perr[k] = 1;
                end else if (en) begin
                    e_samp[k] = 0;
                end
            end
        end
        e8 = 8'(e_samp[0]);
        e6 = 6'(e_samp[1]);
        check("bit0",    32'(bus0.o_bit),          32'(e_bit[0]));
        check("samp0",   32'(bus0.o_sample),       32'(e8));
        check("sv0",     32'(bus0.o_sample_valid), 32'(e_sv[0]));
        check("per0",    32'(bus0.o_period),       32'(e_per[0]));
        check("perr0",   32'(bus0.o_phase_err),    32'(e_perr[0]));
        check("lfsr0",   32'(bus0.o_lfsr),         32'(exp_lfsr(0)));
        check("bit1",    32'(bus1.o_bit),          32'(e_bit[1]));
        check("samp1",   32'(bus1.o_sample),       32'(e6));
        check("sv1",     32'(bus1.o_sample_valid), 32'(e_sv[1]));
        check("per1",    32'(bus1.o_period),       32'(e_per[1]));
        check("perr1",   32'(bus1.o_phase_err),    32'(e_perr[1]));
        check("lfsr1",   32'(bus1.o_lfsr),         32'(exp_lfsr(1)));
    endtask

    int         first_samp [9] = '{64, 0, 0, 0, 64, 0, 0, 0, -64};
    logic       first_bits [9] = '{1, 1, 0, 1, 0, 1, 0, 1, 0};
    logic       bits [$];
    int         ones, periods, period_at;
    logic [8:0] period_lfsr;
    logic [7:0] fs;
    bit         neg_done;

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 2100; i++)
                s[k][i] = (i < 9) ? seeds[k][8-i] : s[k][i-9] ^ s[k][i-5];
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        check("rst_lfsr0", 32'(bus0.o_lfsr), 32'(9'h1AA));
        check("rst_lfsr1", 32'(bus1.o_lfsr), 32'(9'h1FF));
        // one full PRBS period with the upstream 1-in-4 strobe pattern
        ones = 0; periods = 0; period_at = 0; period_lfsr = '0; neg_done = 0;
        for (int i = 0; i < 511 * 4; i++) begin
            step(0, 1, (i % 4) == 0, 3'(i % 4));
            if (i < 9) begin
                fs = 8'(first_samp[i]);
                check("first_samp", 32'(bus0.o_sample), 32'(fs));
            end
            if (i == 0) check("zs_first_pos", 32'(bus1.o_sample), 32'(6'b011111));
            if ((i % 4) == 0) begin
                bits.push_back(bus0.o_bit);
                if (bus0.o_bit) ones++;
                if (!neg_done && !bus1.o_bit) begin
                    check("zs_neg", 32'(bus1.o_sample), 32'(6'b100001));
                    neg_done = 1;
                end
            end
            if (bus0.o_period) begin
                periods++;
                period_at = i / 4 + 1;
                period_lfsr = bus0.o_lfsr;
            end
        end
        for (int j = 0; j < 9; j++) check("first_bits", 32'(bits[j]), 32'(first_bits[j]));
        check("ones", 32'(ones), 32'd256);
        check("periods", 32'(periods), 32'd1);
        check("period_at", 32'(period_at), 32'd511);
        check("period_lfsr", 32'(period_lfsr), 32'(9'h1AA));
        // stall with valid held high, then resume the pattern
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 40; i++) step(0, 1, (i % 4) == 0, 3'(i % 4));
        // randomized aligned traffic
        for (int i = 0; i < 200; i++)
            step(0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, 3'd0);
        check("perr_clean", 32'(bus0.o_phase_err), 32'd0);
        step(0, 1, 1, 3'd2);
        check("perr_set", 32'(bus0.o_phase_err), 32'd1);
        for (int i = 0; i < 8; i++) step(0, 1, (i % 4) == 3, 3'((i + 1) % 4));
        check("perr_sticky", 32'(bus0.o_phase_err), 32'd1);
        for (int i = 0; i < 200; i++)
            step(0, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 3)));
        // reset after 100 advances, reset dominating enable and valid
        step(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) step(0, 1, (i % 4) == 0, 3'(i % 4));
        step(1, 1, 1, 0);
        check("mid_rst_lfsr", 32'(bus0.o_lfsr), 32'(9'h1AA));
        check("mid_rst_perr", 32'(bus0.o_phase_err), 32'd0);
        periods = 0; period_at = 0;
        for (int i = 0; i < 511 * 4; i++) begin
            step(0, 1, (i % 4) == 0, 3'(i % 4));
            if (bus0.o_period) begin
                periods++;
                period_at = i / 4 + 1;
            end
        end
        check("rst_periods", 32'(periods), 32'd1);
        check("rst_period_at", 32'(period_at), 32'd511);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prbs9_upsampler.md
# prbs9_upsampler

Downstream consumer of the PRBS enable counter in the TX example chain. Advances a PRBS9 LFSR (x^9 + x^5 + 1) once per valid strobe from the counter and emits one ±AMPLITUDE impulse per symbol, with zeros in the remaining phases. This gives a 4x zero-stuffed sample stream ready for the pulse-shaping filter. It also flags one full PRBS period and detects strobe/phase misalignment.

## Interface
- SEED, 9'h1AA, LFSR reset value; 9'h000 is illegal and is replaced by 9'h1FF.
- NB_SAMPLE, 8, width of o_sample (two's complement).
- AMPLITUDE, 64, impulse magnitude; must satisfy 0 < AMPLITUDE < 2^(NB_SAMPLE-1).
- clock  input  1  system clock; all logic on rising edge.
- i_reset  input  1  reset, synchronous, active-high.
- i_enable  input  1  global clock enable; when low, all state holds.
- i_valid  input  1  symbol strobe from the counter (o_validPrbs).
- i_phase  input  3  oversampling phase from the counter (o_counter_mux), range 0..3.
- o_bit  output  1  last PRBS bit produced.
- o_sample  output  NB_SAMPLE  upsampled symbol stream.
- o_sample_valid  output  1  o_sample updated this cycle.
- o_period  output  1  one-cycle pulse when 511 advances complete.
- o_phase_err  output  1  sticky misalignment flag.
- o_lfsr  output  9  current LFSR state (debug).

## Operation
- Advance condition: `adv = i_enable & i_valid`.
- On adv:
  - o_bit <= lfsr[8].
  - lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]}.
  - o_sample <= lfsr[8] ? +AMPLITUDE : -AMPLITUDE, sign-extended/negated in NB_SAMPLE bits.
- On `i_enable & ~i_valid`: o_sample <= 0; o_bit and lfsr hold.
- o_sample_valid <= i_enable.
- Period counter (9 bits, 0..510):
  - Increments on adv.
  - On adv at 510, it wraps to 0 and o_period <= 1; o_period is otherwise 0.
- o_phase_err:
  - Set when adv and i_phase != 0.
  - Cleared only by reset.
  - The misaligned strobe still advances and still emits its impulse.
- i_phase is otherwise used only for the error check. Symbol placement follows i_valid.
- i_enable low: lfsr, counter, o_bit, o_sample and o_phase_err hold; o_sample_valid = 0 and o_period = 0.

## Timing
- Reset values:
  - lfsr = SEED, or 9'h1FF if SEED is 0.
  - period counter = 0.
  - o_bit = 0, o_sample = 0, o_sample_valid = 0, o_period = 0, o_phase_err = 0.
- Latency: adv at edge N → o_bit, o_sample and o_lfsr show the new values after edge N (registered, 1 cycle). There is no combinational path from inputs to outputs.
- Upstream gives i_valid = 1 for one enabled cycle with i_phase = 0, every 4 enabled cycles. The resulting o_sample pattern is ±A, 0, 0, 0 repeating.
- If i_valid stays high across i_enable-low cycles, no advance occurs until i_enable returns.
- Reset dominates enable and valid in the same cycle. Reset mid-sequence restarts at SEED with the counter at 0; the next o_period comes 511 advances later.
- o_period coincides with the o_bit/o_sample update of the 511th advance.
- The LFSR never reaches the all-zero state, because SEED is non-zero.

## Test plan
- First bits after reset: reset, then SEED = 9'h1AA with i_enable = 1 and the upstream counter pattern → first 9 o_bit values are 1,1,0,1,0,1,0,1,0; first o_sample values are +64, 0, 0, 0, +64, 0, 0, 0, -64, ...
- Full period: 511 advances → exactly one o_period pulse, on the 511th advance.
  - o_lfsr == 9'h1AA again at that point.
  - The bit sequence matches a reference x^9+x^5+1 model; 256 ones and 255 zeros.
- Enable stall: i_enable low for 5 cycles mid-sequence with i_valid held high → all outputs frozen; o_sample_valid = 0; the bit sequence continues unbroken once i_enable returns.
- Misalignment: i_valid = 1 with i_phase = 2 → the impulse is still emitted and o_phase_err = 1 from the next cycle. It stays set through later aligned strobes until i_reset.
- Reset mid-run: i_reset after 100 advances → all outputs are 0 and o_lfsr = 9'h1AA the next cycle; the sequence restarts from the first bit; o_period arrives 511 advances later.
- Zero seed: SEED = 0, NB_SAMPLE = 6, AMPLITUDE = 31 → o_lfsr = 9'h1FF after reset; the first impulse is +31 (6'b011111) and later -31 values appear as 6'b100001.
